// File: rtl/bmi_seq_calc_if.sv
`default_nettype none
// ============================================================================
// Module   : bmi_seq_calc_if
// Purpose  : Request/response bundle between a BMI requester and bmi_seq_calc.
// Revision : 1.0 - initial release
// ============================================================================
interface bmi_seq_calc_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] wm;
    logic [DATA_W-1:0] hm;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] bmi;
    logic              sat;
    logic              err;

    modport master (
        output start, wm, hm,
        input  busy, done, bmi, sat, err
    );

    modport slave (
        input  start, wm, hm,
        output busy, done, bmi, sat, err
    );
endinterface
`default_nettype wire

// File: rtl/bmi_seq_calc.sv
`default_nettype none
// ============================================================================
// Module   : bmi_seq_calc
// Purpose  : Fixed-latency BMI = floor(wm*SCALE / hm^2) via bit-serial divider.
// Revision : 1.0 - initial release
// ============================================================================
module bmi_seq_calc #(
    parameter int DATA_W = 8,
    parameter int SCALE  = 10000,
    parameter int NUM_W  = 22
) (
    input  wire logic      clk,
    input  wire logic      rst,
    bmi_seq_calc_if.slave  bus
);
    localparam int DEN_W = 2 * DATA_W;
    localparam int REM_W = 2 * DATA_W + 1;
    localparam int CNT_W = $clog2(NUM_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_W-1:0]   r_num,   w_num_nxt;
    logic [DEN_W-1:0]   r_den,   w_den_nxt;
    logic [REM_W-1:0]   r_rem,   w_rem_nxt;
    logic [NUM_W-1:0]   r_quo,   w_quo_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic               r_err_int, w_err_int_nxt;
    logic               r_busy,  w_busy_nxt;
    logic               r_done,  w_done_nxt;
    logic [DATA_W-1:0]  r_bmi,   w_bmi_nxt;
    logic               r_sat,   w_sat_nxt;
    logic               r_err,   w_err_nxt;
    logic [REM_W-1:0]   w_rem_sh;
    logic               w_fits;

    always_comb begin
        w_state_nxt   = r_state;
        w_num_nxt     = r_num;
        w_den_nxt     = r_den;
        w_rem_nxt     = r_rem;
        w_quo_nxt     = r_quo;
        w_cnt_nxt     = r_cnt;
        w_err_int_nxt = r_err_int;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_bmi_nxt     = r_bmi;
        w_sat_nxt     = r_sat;
        w_err_nxt     = r_err;
        // Remainder is one bit wider than the divisor so the shifted trial never overflows.
        w_rem_sh      = (r_rem << 1) | REM_W'(r_num[NUM_W-1]);
        w_fits        = (w_rem_sh >= {1'b0, r_den});

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_num_nxt     = NUM_W'(bus.wm) * NUM_W'(SCALE);
                    w_den_nxt     = DEN_W'(bus.hm) * DEN_W'(bus.hm);
                    w_rem_nxt     = '0;
                    w_quo_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_err_int_nxt = (bus.hm == '0);
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_DIV;
                end
            end
            S_DIV: begin
                w_num_nxt = r_num << 1;
                if (w_fits) begin
                    w_rem_nxt = w_rem_sh - {1'b0, r_den};
                    w_quo_nxt = (r_quo << 1) | NUM_W'(1);
                end else begin
                    w_rem_nxt = w_rem_sh;
                    w_quo_nxt = r_quo << 1;
                end
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(NUM_W - 1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // First DONE cycle publishes the result, second one retires the request.
                if (!r_done) begin
                    w_done_nxt = 1'b1;
                    if (r_err_int) begin
                        w_bmi_nxt = '0;
                        w_sat_nxt = 1'b0;
                        w_err_nxt = 1'b1;
                    end else if (|r_quo[NUM_W-1:DATA_W]) begin
                        w_bmi_nxt = '1;
                        w_sat_nxt = 1'b1;
                        w_err_nxt = 1'b0;
                    end else begin
                        w_bmi_nxt = r_quo[DATA_W-1:0];
                        w_sat_nxt = 1'b0;
                        w_err_nxt = 1'b0;
                    end
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num     <= '0;
            r_den     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_err_int <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bmi     <= '0;
            r_sat     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_num     <= w_num_nxt;
            r_den     <= w_den_nxt;
            r_rem     <= w_rem_nxt;
            r_quo     <= w_quo_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err_int <= w_err_int_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_bmi     <= w_bmi_nxt;
            r_sat     <= w_sat_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bmi  = r_bmi;
    assign bus.sat  = r_sat;
    assign bus.err  = r_err;
endmodule
`default_nettype wire

// File: tb/tb_bmi_seq_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmi_seq_calc
// Purpose  : Self-checking bench for bmi_seq_calc against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bmi_seq_calc;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bmi_seq_calc_if #(.DATA_W(DATA_W)) bus ();

    bmi_seq_calc #(
        .DATA_W (DATA_W),
        .SCALE  (10000),
        .NUM_W  (22)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: BMI straight from the formula, saturated, hm==0 flagged.
    function automatic void model(input int w, input int h,
                                  output int eb, output bit es, output bit ee);
        int q;
        if (h == 0) begin
            eb = 0; es = 1'b0; ee = 1'b1;
        end else begin
            q  = (w * 10000) / (h * h);
            ee = 1'b0;
            if (q > 255) begin
                eb = 255; es = 1'b1;
            end else begin
                eb = q;   es = 1'b0;
            end
        end
    endfunction

    task automatic run_req(input int w, input int h, input int eb,
                           input bit es, input bit ee, input string tag);
        int n;
        bit busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        bus.wm    = w[7:0];
        bus.hm    = h[7:0];
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            step();
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 23) begin
            errors++;
            $display("FAIL %s latency got %0d want 23", tag, n);
        end
        checks++;
        if (!busy_ok || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_during got low want high", tag);
        end
        checks++;
        if (bus.bmi !== 8'(eb)) begin
            errors++;
            $display("FAIL %s bmi got %0d want %0d", tag, bus.bmi, eb);
        end
        checks++;
        if (bus.sat !== es || bus.err !== ee) begin
            errors++;
            $display("FAIL %s flags got sat=%b err=%b want sat=%b err=%b",
                     tag, bus.sat, bus.err, es, ee);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s retire got done=%b busy=%b want 0 0", tag, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.wm    = '0;
        bus.hm    = '0;
        rst       = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.bmi !== 8'd0)  begin errors++; $display("FAIL reset_bmi got %0d want 0", bus.bmi); end
        checks++; if (bus.sat !== 1'b0)  begin errors++; $display("FAIL reset_sat got %b want 0", bus.sat); end
        checks++; if (bus.err !== 1'b0)  begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    endtask

    task automatic test_directed();
        run_req(70, 175, 22, 1'b0, 1'b0, "w70h175");
        run_req(100, 100, 100, 1'b0, 1'b0, "w100h100");
        run_req(80, 160, 31, 1'b0, 1'b0, "w80h160");
        run_req(255, 50, 255, 1'b1, 1'b0, "w255h50");
        repeat (5) step();
        checks++;
        if (bus.bmi !== 8'd255 || bus.sat !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL hold got bmi=%0d sat=%b done=%b want 255 1 0", bus.bmi, bus.sat, bus.done);
        end
        run_req(0, 180, 0, 1'b0, 1'b0, "w0h180");
        run_req(60, 0, 0, 1'b0, 1'b1, "w60h0");
    endtask

    task automatic test_ignore_start();
        int  done_cnt;
        int  done_at;
        int  bmi_at;
        bit  busy_bad;
        done_cnt = 0; done_at = 0; bmi_at = -1; busy_bad = 1'b0;
        bus.wm = 8'd70; bus.hm = 8'd175; bus.start = 1'b1;
        step();
        for (int cyc = 1; cyc <= 35; cyc++) begin
            if (cyc == 5 || cyc == 23) begin
                bus.start = 1'b1; bus.wm = 8'd200; bus.hm = 8'd90;
            end else begin
                bus.start = 1'b0;
            end
            step();
            if (bus.done === 1'b1) begin
                done_cnt++; done_at = cyc; bmi_at = int'(bus.bmi);
            end
            if (cyc >= 24 && bus.busy !== 1'b0) busy_bad = 1'b1;
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignore_count got %0d want 1", done_cnt); end
        checks++; if (done_at !== 23) begin errors++; $display("FAIL ignore_latency got %0d want 23", done_at); end
        checks++; if (bmi_at !== 22)  begin errors++; $display("FAIL ignore_bmi got %0d want 22", bmi_at); end
        checks++; if (busy_bad)       begin errors++; $display("FAIL ignore_busy got high want low after retire"); end
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        seen_done = 1'b0;
        bus.wm = 8'd100; bus.hm = 8'd100; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bmi !== 8'd0 ||
            bus.sat !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL midreset got busy=%b done=%b bmi=%0d sat=%b err=%b want all 0",
                     bus.busy, bus.done, bus.bmi, bus.sat, bus.err);
        end
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin errors++; $display("FAIL midreset_quiet got activity want none"); end
        run_req(80, 160, 31, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int d1, d2, b1, b2;
        bit busy24, busy25;
        d1 = 0; d2 = 0; b1 = -1; b2 = -1; busy24 = 1'b1; busy25 = 1'b0;
        bus.wm = 8'd100; bus.hm = 8'd100; bus.start = 1'b1;
        step();
        bus.wm = 8'd80; bus.hm = 8'd160;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 24) busy24 = bus.busy;
            if (i == 25) begin busy25 = bus.busy; bus.start = 1'b0; end
            if (bus.done === 1'b1) begin
                if (d1 == 0) begin d1 = i; b1 = int'(bus.bmi); end
                else if (d2 == 0) begin d2 = i; b2 = int'(bus.bmi); end
            end
        end
        checks++; if (d1 !== 23 || b1 !== 100) begin errors++; $display("FAIL b2b_first got at=%0d bmi=%0d want 23 100", d1, b1); end
        checks++; if (busy24 !== 1'b0 || busy25 !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b%b want 01", busy24, busy25); end
        checks++; if (d2 !== 48 || b2 !== 31) begin errors++; $display("FAIL b2b_second got at=%0d bmi=%0d want 48 31", d2, b2); end
    endtask

    task automatic test_random();
        int w, h, eb;
        bit es, ee;
        for (int i = 0; i < 20; i++) begin
            w = int'($urandom_range(0, 255));
            h = (i % 4 == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 255));
            model(w, h, eb, es, ee);
            run_req(w, h, eb, es, ee, $sformatf("rnd%0d_w%0d_h%0d", i, w, h));
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
